// File: rtl/datactrl_pkg.sv
// Shared constants, state encoding and width helpers for the data-side memory controller.
package datactrl_pkg;

    localparam int AddressWidth = 32;
    localparam int IDWidth      = 32;

    // addr[17:16] value that selects the memory-mapped IO region
    localparam logic [1:0] IO_HI = 2'b11;

    // Width codes double as byte counts
    localparam logic [2:0] W_BYTE = 3'b001;
    localparam logic [2:0] W_HALF = 3'b010;
    localparam logic [2:0] W_WORD = 3'b100;

    typedef enum logic [1:0] {
        DC_IDLE  = 2'd0,
        DC_LOAD  = 2'd1,
        DC_STORE = 2'd2
    } dc_state_e;

    // Any width code other than byte or half is handled as a full word
    function automatic logic [2:0] norm_width(input logic [2:0] w);
        case (w)
            W_BYTE:  return W_BYTE;
            W_HALF:  return W_HALF;
            default: return W_WORD;
        endcase
    endfunction

endpackage

// File: rtl/datactrl_extend.sv
// Sign/zero extension of an assembled little-endian load word.
module datactrl_extend
    import datactrl_pkg::*;
(
    input  logic [IDWidth-1:0] raw_word,
    input  logic [2:0]         width,
    input  logic               sgn,
    output logic [IDWidth-1:0] ext_word
);

    // Replicate the top loaded bit when signed, zero-fill otherwise; words pass through
    always_comb begin
        case (width)
            W_BYTE:  ext_word = {{(IDWidth-8){sgn & raw_word[7]}}, raw_word[7:0]};
            W_HALF:  ext_word = {{(IDWidth-16){sgn & raw_word[15]}}, raw_word[15:0]};
            default: ext_word = raw_word;
        endcase
    end

endmodule

// File: rtl/datactrl.sv
// Data-side memory controller: serialises one load or store at a time into
// little-endian byte accesses on the RAM/IO port.
//
// state    | meaning
// DC_IDLE  | waiting for a request or for the pending load slot
// DC_LOAD  | issuing load byte addresses and collecting bytes one cycle later
// DC_STORE | issuing store bytes; held in place while the IO buffer is full
module datactrl
    import datactrl_pkg::*;
(
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    rob_datactrl_rst_in,
    input  logic                    lbuffer_datactrl_en_in,
    input  logic [AddressWidth-1:0] lbuffer_datactrl_addr_in,
    input  logic [2:0]              lbuffer_datactrl_width_in,
    input  logic                    lbuffer_datactrl_sgn_in,
    output logic                    datactrl_lbuffer_en_out,
    output logic [IDWidth-1:0]      datactrl_lbuffer_data_out,
    input  logic                    sbuffer_datactrl_en_in,
    input  logic [AddressWidth-1:0] sbuffer_datactrl_addr_in,
    input  logic [2:0]              sbuffer_datactrl_width_in,
    input  logic [IDWidth-1:0]      sbuffer_datactrl_data_in,
    output logic                    datactrl_sbuffer_en_out,
    input  logic                    io_buffer_full_in,
    input  logic [7:0]              mem_din_in,
    output logic [7:0]              mem_dout_out,
    output logic [AddressWidth-1:0] mem_a_out,
    output logic                    mem_wr_out
);

    dc_state_e               state;
    logic [2:0]              k;
    logic [2:0]              k_nxt;
    logic [AddressWidth-1:0] base_q;
    logic [2:0]              width_q;
    logic                    sgn_q;
    logic [IDWidth-1:0]      sdata_q;
    logic [IDWidth-1:0]      lbuf_q;

    logic                    pend_vld;
    logic [AddressWidth-1:0] pend_addr;
    logic [2:0]              pend_width;
    logic                    pend_sgn;

    logic [AddressWidth-1:0] mem_a_q;
    logic [7:0]              mem_dout_q;
    logic                    lb_en_q;
    logic                    sb_en_q;
    logic [IDWidth-1:0]      ld_data_q;

    logic                    flush;
    logic                    io_stall;
    logic [AddressWidth-1:0] addr_nxt;
    logic [7:0]              st_byte_nxt;
    logic [IDWidth-1:0]      ld_word;
    logic [IDWidth-1:0]      ld_ext;

    logic                    ld_start;
    logic [AddressWidth-1:0] ld_addr_sel;
    logic [2:0]              ld_width_sel;
    logic                    ld_sgn_sel;

    assign flush       = rob_datactrl_rst_in;
    assign k_nxt       = k + 3'd1;
    assign addr_nxt    = base_q + AddressWidth'(k_nxt);
    assign st_byte_nxt = sdata_q[{k_nxt[1:0], 3'b000} +: 8];
    assign io_stall    = (state == DC_STORE) && (base_q[17:16] == IO_HI) && io_buffer_full_in;

    // A pending load always wins over a fresh load request; a store beats both
    assign ld_start     = !sbuffer_datactrl_en_in && !flush && (pend_vld || lbuffer_datactrl_en_in);
    assign ld_addr_sel  = pend_vld ? pend_addr  : lbuffer_datactrl_addr_in;
    assign ld_width_sel = pend_vld ? pend_width : norm_width(lbuffer_datactrl_width_in);
    assign ld_sgn_sel   = pend_vld ? pend_sgn   : lbuffer_datactrl_sgn_in;

    // Byte addressed in the previous cycle arrives now; merge it into the partial word
    always_comb begin
        ld_word = lbuf_q;
        case (k)
            3'd1:    ld_word[7:0]   = mem_din_in;
            3'd2:    ld_word[15:8]  = mem_din_in;
            3'd3:    ld_word[23:16] = mem_din_in;
            3'd4:    ld_word[31:24] = mem_din_in;
            default: ld_word = lbuf_q;
        endcase
    end

    datactrl_extend u_extend (
        .raw_word (ld_word),
        .width    (width_q),
        .sgn      (sgn_q),
        .ext_word (ld_ext)
    );

    // Request arbitration, byte sequencing and registered port outputs
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state      <= DC_IDLE;
            k          <= 3'd0;
            base_q     <= '0;
            width_q    <= W_WORD;
            sgn_q      <= 1'b0;
            sdata_q    <= '0;
            lbuf_q     <= '0;
            pend_vld   <= 1'b0;
            pend_addr  <= '0;
            pend_width <= W_WORD;
            pend_sgn   <= 1'b0;
            mem_a_q    <= '0;
            mem_dout_q <= 8'h00;
            lb_en_q    <= 1'b0;
            sb_en_q    <= 1'b0;
            ld_data_q  <= '0;
        end else if (rdy_in) begin
            lb_en_q <= 1'b0;
            sb_en_q <= 1'b0;
            if (flush) begin
                pend_vld <= 1'b0;
            end
            case (state)
                DC_IDLE: begin
                    if (sbuffer_datactrl_en_in) begin
                        state      <= DC_STORE;
                        k          <= 3'd0;
                        base_q     <= sbuffer_datactrl_addr_in;
                        width_q    <= norm_width(sbuffer_datactrl_width_in);
                        sdata_q    <= sbuffer_datactrl_data_in;
                        mem_a_q    <= sbuffer_datactrl_addr_in;
                        mem_dout_q <= sbuffer_datactrl_data_in[7:0];
                        if (lbuffer_datactrl_en_in && !flush) begin
                            pend_vld   <= 1'b1;
                            pend_addr  <= lbuffer_datactrl_addr_in;
                            pend_width <= norm_width(lbuffer_datactrl_width_in);
                            pend_sgn   <= lbuffer_datactrl_sgn_in;
                        end
                    end else if (ld_start) begin
                        state    <= DC_LOAD;
                        k        <= 3'd0;
                        base_q   <= ld_addr_sel;
                        width_q  <= ld_width_sel;
                        sgn_q    <= ld_sgn_sel;
                        mem_a_q  <= ld_addr_sel;
                        lbuf_q   <= '0;
                        pend_vld <= 1'b0;
                    end
                end
                DC_LOAD: begin
                    if (flush) begin
                        state <= DC_IDLE;
                    end else begin
                        lbuf_q <= ld_word;
                        if (k_nxt < width_q) begin
                            mem_a_q <= addr_nxt;
                        end
                        if (k == width_q) begin
                            state     <= DC_IDLE;
                            lb_en_q   <= 1'b1;
                            ld_data_q <= ld_ext;
                        end
                        k <= k_nxt;
                    end
                end
                DC_STORE: begin
                    if (!io_stall) begin
                        if (k_nxt == width_q) begin
                            state   <= DC_IDLE;
                            sb_en_q <= 1'b1;
                        end else begin
                            k          <= k_nxt;
                            mem_a_q    <= addr_nxt;
                            mem_dout_q <= st_byte_nxt;
                        end
                    end
                end
                default: state <= DC_IDLE;
            endcase
        end
    end

    assign mem_wr_out                = rdy_in && (state == DC_STORE) && !io_stall;
    assign mem_a_out                 = mem_a_q;
    assign mem_dout_out              = mem_dout_q;
    assign datactrl_lbuffer_en_out   = lb_en_q;
    assign datactrl_lbuffer_data_out = ld_data_q;
    assign datactrl_sbuffer_en_out   = sb_en_q;

endmodule

// File: doc/datactrl.md
Name: datactrl

Overview:
- Data-side memory controller between the load buffer / store buffer and the byte-wide RAM/IO port.
- Accepts one load or store request at a time and serialises it into 1, 2 or 4 little-endian byte accesses.
- For loads: assembles and sign/zero-extends the result, then pulses completion back to the load buffer.
- For stores: pulses completion to the store buffer.
- Its memory port is muxed onto RAM by the top-level memory arbiter.

Parameters:
- AddressWidth, 32, address bus width.
- IDWidth, 32, data word width.
- IO_HI, 2'b11, value of addr[17:16] that marks the IO region.

Ports:
- clk_in  in  1  clock; all state changes on posedge.
- rst_in  in  1  synchronous reset, active-low (0 = reset).
- rdy_in  in  1  global enable; 0 freezes all state.
- rob_datactrl_rst_in  in  1  misprediction flush.
- lbuffer_datactrl_en_in  in  1  load request pulse.
- lbuffer_datactrl_addr_in  in  32  load byte address.
- lbuffer_datactrl_width_in  in  3  bytes: 3'b001 / 3'b010 / 3'b100.
- lbuffer_datactrl_sgn_in  in  1  1 = sign-extend.
- datactrl_lbuffer_en_out  out  1  load done pulse.
- datactrl_lbuffer_data_out  out  32  extended load result.
- sbuffer_datactrl_en_in  in  1  store request pulse.
- sbuffer_datactrl_addr_in  in  32  store byte address.
- sbuffer_datactrl_width_in  in  3  bytes: 1 / 2 / 4.
- sbuffer_datactrl_data_in  in  32  store data (low bytes used).
- datactrl_sbuffer_en_out  out  1  store done pulse.
- io_buffer_full_in  in  1  UART buffer full.
- mem_din_in  in  8  RAM read byte, valid one cycle after its address.
- mem_dout_out  out  8  write byte.
- mem_a_out  out  32  byte address.
- mem_wr_out  out  1  1 = write.

Behaviour:
- Reset (rst_in==0 at posedge):
  - State IDLE, pending slot empty.
  - All outputs 0: both en_out, data_out, mem_a_out, mem_dout_out, mem_wr_out.
  - Reset mid-transfer abandons the transfer with no done pulse.
- rdy_in==0:
  - No state, counter or output register changes.
  - mem_wr_out is forced 0 combinationally.
  - Request pulses arriving while rdy_in==0 are lost; requesters only pulse with rdy_in high.
- Requests:
  - Single-cycle pulses, sampled only in IDLE. Requesters never pulse while their previous request is outstanding.
  - Load and store in the same IDLE cycle: the store is accepted; the load is latched into a one-entry pending slot and started in the cycle after store done.
- FSM states: IDLE, LOAD, STORE.
  - IDLE→LOAD/STORE on accept, or IDLE→LOAD from the pending slot.
  - LOAD/STORE→IDLE after the final byte.
  - Byte counter k runs 0..w-1, where w = width.
  - Width values other than 1/2/4 are treated as 4.
- Load timing (request cycle = 0):
  - Cycles 1..w: mem_a_out = addr+k-1, mem_wr_out = 0.
  - Byte k-1 is captured from mem_din_in in cycle k+1.
  - datactrl_lbuffer_en_out is high for exactly one cycle, in cycle w+2, with data_out valid in the same cycle.
  - data_out holds its value afterwards.
  - Latency: LB = 3, LH = 4, LW = 6.
- Extension:
  - sgn=1, w=1: replicate bit 7.
  - sgn=1, w=2: replicate bit 15.
  - sgn=0: zero-fill.
  - w=4: no extension.
- Store timing:
  - Cycles 1..w: mem_a_out = addr+k-1, mem_wr_out = 1, mem_dout_out = data[8(k-1)+7 : 8(k-1)].
  - datactrl_sbuffer_en_out pulses one cycle in cycle w+1.
- IO stall:
  - Applies in STORE when addr[17:16]==IO_HI and io_buffer_full_in==1.
  - mem_wr_out = 0 and k does not advance; the byte is retried next cycle.
  - Loads never stall.
- Address arithmetic: addr+k is 32-bit modulo; wraps at 2^32.
- Flush (rob_datactrl_rst_in==1):
  - An active load returns to IDLE with no done pulse.
  - The pending load slot is cleared.
  - A load request in the same cycle is dropped.
  - An active STORE (committed) runs to completion, and a same-cycle store request is still accepted.
  - If the flush coincides with the cycle a load done pulse is due, the pulse is suppressed.
- Idle outputs: mem_wr_out = 0; mem_a_out holds its last value.

Decomposition:
- constant.vh gets:
  - state encodings DC_IDLE / DC_LOAD / DC_STORE;
  - width codes `W_BYTE 3'b001, `W_HALF 3'b010, `W_WORD 3'b100;
  - `IO_HI.
- AddressWidth and IDWidth are already there.
- One combinational sub-module, datactrl_extend: (raw 32-bit, width, sgn) → extended 32-bit result.
- Everything else stays in datactrl.

Test Plan:
- LW at 0x0000_0100, RAM bytes 11 22 33 44, sgn=0 → en_out high only in cycle 6, data 0x44332211; mem_a_out 0x100..0x103 in cycles 1..4.
- LB sgn=1 at a byte 0x80 → data 0xFFFF_FF80 at cycle 3; LBU on the same byte → 0x0000_0080; LH sgn=1 on bytes 34 92 → 0xFFFF_9234 at cycle 4.
- SW 0xDEADBEEF at 0x200 → writes EF AD... in order EF, BE, AD, DE to 0x200..0x203 with mem_wr_out=1 in cycles 1..4; store done pulse in cycle 5.
- Simultaneous SB to 0x30000 and LW in one IDLE cycle, io_buffer_full_in high for 3 cycles → SB byte issued only after full drops; the load starts the cycle after store done and returns a correct word.
- LW in flight, flush in cycle 3 → no load done pulse ever; IDLE by cycle 4; the next load completes normally. SW in flight plus flush → store completes and pulses.
- rst_in=0 asserted mid-LW, then rdy_in=0 held 2 cycles during a later SH → all outputs 0 after reset; SH latency stretched by exactly 2 cycles with mem_wr_out 0 during the freeze.
